pipe_mult: RTL and testbench



---
 rtl/pipe_mult.sv | 81 ++++++++
 tb/tb_pipe_mult.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mult.sv
// Free-running pipelined integer multiplier with per-job unsigned/two's-complement
// selection; latency NUM_STAGES-1 clocks, one job accepted every cycle.
module pipe_mult #(
  parameter int A_WIDTH    = 53,
  parameter int B_WIDTH    = 53,
  parameter int NUM_STAGES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       tc,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  logic signed [P_W-1:0] w_product;

  function automatic logic signed [P_W-1:0] ext_a(input logic [A_WIDTH-1:0] v, input logic s);
    return s ? {{B_WIDTH{v[A_WIDTH-1]}}, v} : {{B_WIDTH{1'b0}}, v};
  endfunction

  function automatic logic signed [P_W-1:0] ext_b(input logic [B_WIDTH-1:0] v, input logic s);
    return s ? {{A_WIDTH{v[B_WIDTH-1]}}, v} : {{A_WIDTH{1'b0}}, v};
  endfunction

  // With both operands extended to the full product width, the low P_W bits of
  // the product are exact for signed and unsigned interpretation alike.
  function automatic logic signed [P_W-1:0] mul_full(input logic signed [P_W-1:0] x,
                                                     input logic signed [P_W-1:0] y);
    return x * y;
  endfunction

  if (NUM_STAGES == 2) begin : g_single
    logic signed [P_W-1:0] r_prod_p0;

    // p0: single rank, multiply straight from the ports
    always_ff @(posedge clk) begin
      if (rst) begin
        r_prod_p0 <= '0;
      end else begin
        r_prod_p0 <= mul_full(ext_a(a, tc), ext_b(b, tc));
      end
    end

    assign w_product = r_prod_p0;
  end else begin : g_multi
    localparam int PR = NUM_STAGES - 2;

    logic [A_WIDTH-1:0]    r_a_p0;
    logic [B_WIDTH-1:0]    r_b_p0;
    logic                  r_tc_p0;
    logic signed [P_W-1:0] r_prod_pn [PR];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_a_p0  <= '0;
        r_b_p0  <= '0;
        r_tc_p0 <= 1'b0;
        for (int i = 0; i < PR; i++) begin
          r_prod_pn[i] <= '0;
        end
      end else begin
        // p0: operand capture; p1: multiply; p2..: retiming ranks
        r_a_p0       <= a;
        r_b_p0       <= b;
        r_tc_p0      <= tc;
        r_prod_pn[0] <= mul_full(ext_a(r_a_p0, r_tc_p0), ext_b(r_b_p0, r_tc_p0));
        for (int i = 1; i < PR; i++) begin
          r_prod_pn[i] <= r_prod_pn[i-1];
        end
      end
    end

    assign w_product = r_prod_pn[PR-1];
  end

  assign product = w_product;

endmodule

// File: tb/tb_pipe_mult.sv
// Bench for pipe_mult: three configurations (53x53/4, 8x8/2, 106x53/5) checked
// every cycle against a value-level delay-line model, plus directed literals.
module tb_pipe_mult;

  logic         clk;
  logic         rst;
  logic [52:0]  a0, b0;
  logic         tc0;
  logic [105:0] prod0;
  logic [7:0]   a1, b1;
  logic         tc1;
  logic [15:0]  prod1;
  logic [105:0] a2;
  logic [52:0]  b2;
  logic         tc2;
  logic [158:0] prod2;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_mult #(.A_WIDTH(53), .B_WIDTH(53), .NUM_STAGES(4)) u_dut0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0), .tc(tc0), .product(prod0));
  pipe_mult #(.A_WIDTH(8), .B_WIDTH(8), .NUM_STAGES(2)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .tc(tc1), .product(prod1));
  pipe_mult #(.A_WIDTH(106), .B_WIDTH(53), .NUM_STAGES(5)) u_dut2 (
    .clk(clk), .rst(rst), .a(a2), .b(b2), .tc(tc2), .product(prod2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value semantics: a set top bit under tc means the operand is v - 2^w.
  function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b,
                                           input int aw, input int bw, input logic tc);
    logic [255:0] av, bv, p;
    av = 256'(a);
    bv = 256'(b);
    if (tc && a[aw-1]) av = av - (256'd1 << aw);
    if (tc && b[bw-1]) bv = bv - (256'd1 << bw);
    p = av * bv;
    return p & ((256'd1 << (aw + bw)) - 256'd1);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd_op(input int w);
    logic [127:0] r;
    case ($urandom_range(0, 7))
      0:       r = (128'd1 << w) - 128'd1;
      1:       r = 128'd1 << (w - 1);
      2:       r = '0;
      3:       r = 128'd1;
      default: r = {$urandom(), $urandom(), $urandom(), $urandom()} & ((128'd1 << w) - 128'd1);
    endcase
    return r;
  endfunction

  // Delay-line model: results due in later cycles wait in a queue; reset empties it.
  logic [255:0] q0[$], q1[$], q2[$];
  logic [255:0] e0, e1, e2;
  bit           mv = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q0.delete(); q1.delete(); q2.delete();
        for (int i = 0; i < 2; i++) q0.push_back('0);
        for (int i = 0; i < 3; i++) q2.push_back('0);
        e0 = '0; e1 = '0; e2 = '0;
        mv = 1'b1;
      end else begin
        q0.push_back(ref_mul(128'(a0), 128'(b0), 53, 53, tc0));
        q1.push_back(ref_mul(128'(a1), 128'(b1), 8, 8, tc1));
        q2.push_back(ref_mul(128'(a2), 128'(b2), 106, 53, tc2));
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        e2 = q2.pop_front();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mv) begin
        check("cmp_53x53", 256'(prod0), e0);
        check("cmp_8x8", 256'(prod1), e1);
        check("cmp_106x53", 256'(prod2), e2);
      end
    end
  end

  logic [127:0] ra, rb;
  logic [52:0]  ja [10];
  logic [52:0]  jb [10];
  logic         jt [10];

  initial begin
    rst = 1'b1;
    a0 = '0; b0 = '0; tc0 = 1'b0;
    a1 = '0; b1 = '0; tc1 = 1'b0;
    a2 = '0; b2 = '0; tc2 = 1'b0;
    tick();
    tick();
    check("reset_53x53", 256'(prod0), '0);
    check("reset_8x8", 256'(prod1), '0);
    check("reset_106x53", 256'(prod2), '0);
    rst = 1'b0;

    // 2^52 * 2^52, result after the third edge
    a0 = 53'd1 << 52; b0 = 53'd1 << 52; tc0 = 1'b0;
    tick();
    check("t1_e0", 256'(prod0), '0);
    a0 = '0; b0 = '0;
    tick();
    check("t1_e1", 256'(prod0), '0);
    tick();
    check("t1_e2", 256'(prod0), 256'd1 << 104);

    // all-ones squared, then a zero operand
    a0 = '1; b0 = '1;
    tick();
    a0 = '0; b0 = '1;
    tick();
    a0 = '0; b0 = '0;
    tick();
    check("t2_ones", 256'(prod0), (256'd1 << 106) - (256'd1 << 54) + 256'd1);
    tick();
    check("t2_zero", 256'(prod0), '0);

    // 8x8 single-rank stream, mixed tc
    a1 = 8'hFF; b1 = 8'h02; tc1 = 1'b0;
    tick();
    check("t3_u_ff_02", 256'(prod1), 256'h01FE);
    a1 = 8'hFF; b1 = 8'h02; tc1 = 1'b1;
    tick();
    check("t3_s_ff_02", 256'(prod1), 256'hFFFE);
    a1 = 8'h80; b1 = 8'h80; tc1 = 1'b1;
    tick();
    check("t3_s_80_80", 256'(prod1), 256'h4000);
    a1 = 8'h80; b1 = 8'h7F; tc1 = 1'b1;
    tick();
    check("t3_s_80_7f", 256'(prod1), 256'hC080);
    a1 = '0; b1 = '0; tc1 = 1'b0;

    // 106x53, five stages
    a2 = 106'd1 << 105; b2 = 53'd1 << 52; tc2 = 1'b0;
    tick();
    a2 = 106'd3 << 104; b2 = 53'd3 << 51;
    tick();
    a2 = '0; b2 = '0;
    tick();
    check("t4_e2", 256'(prod2), '0);
    tick();
    check("t4_pow", 256'(prod2), 256'd1 << 157);
    tick();
    check("t4_nine", 256'(prod2), 256'd9 << 155);

    // ten jobs with a one-cycle reset after the fifth
    for (int i = 0; i < 10; i++) begin
      ra = rnd_op(53); rb = rnd_op(53);
      ja[i] = ra[52:0]; jb[i] = rb[52:0]; jt[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 5; i++) begin
      a0 = ja[i]; b0 = jb[i]; tc0 = jt[i];
      tick();
    end
    rst = 1'b1;
    a0 = '1; b0 = '1; tc0 = 1'b1;
    tick();
    check("t5_rst", 256'(prod0), '0);
    rst = 1'b0;
    for (int i = 5; i < 12; i++) begin
      if (i < 10) begin
        a0 = ja[i]; b0 = jb[i]; tc0 = jt[i];
      end else begin
        a0 = '0; b0 = '0; tc0 = 1'b0;
      end
      tick();
      if (i < 7) check("t5_flush", 256'(prod0), '0);
      else check("t5_post", 256'(prod0),
                 ref_mul(128'(ja[i-2]), 128'(jb[i-2]), 53, 53, jt[i-2]));
    end

    // random regression across all three configurations
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      ra = rnd_op(53);  rb = rnd_op(53);
      a0 = ra[52:0];    b0 = rb[52:0];  tc0 = 1'($urandom_range(0, 1));
      ra = rnd_op(8);   rb = rnd_op(8);
      a1 = ra[7:0];     b1 = rb[7:0];   tc1 = 1'($urandom_range(0, 1));
      ra = rnd_op(106); rb = rnd_op(53);
      a2 = ra[105:0];   b2 = rb[52:0];  tc2 = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
